score_display: RTL
==================

SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 Parameter MAX_SCORE, default 5, is the score that ends a game (1..9).
REQ-002 Parameter PS_X, default SCREEN_H_RES-120, is the player digit top-left x.
REQ-003 Parameter PS_Y, default 50, is the player digit top-left y.
REQ-004 Parameter ES_X, default 120, is the enemy digit top-left x.
REQ-005 Parameter ES_Y, default 50, is the enemy digit top-left y.
REQ-006 Parameter SCALE, default 10, is pixels per glyph cell; glyph is 3*SCALE wide, 5*SCALE tall.
REQ-007 clk_i  in  1  the single clock.
REQ-008 rst_i  in  1  reset, asynchronous, active-high.
REQ-009 start_i  in  1  start/restart request, one-cycle pulse.
REQ-010 p_goal_i  in  1  player scored, one-cycle pulse.
REQ-011 e_goal_i  in  1  enemy scored, one-cycle pulse.
REQ-012 frame_start_i  in  1  one-cycle pulse at the first pixel of each frame.
REQ-013 pix_valid_i  in  1  active-video qualifier for x_pos_i/y_pos_i.
REQ-014 x_pos_i  in  X_POS_W  current pixel column.
REQ-015 y_pos_i  in  Y_POS_W  current pixel row.
REQ-016 score_pix_o  out  1  current pixel belongs to a lit score glyph cell.
REQ-017 pix_valid_o  out  1  pix_valid_i delayed to align with score_pix_o.
REQ-018 p_score_o  out  M_SCORE_W  live player score.
REQ-019 e_score_o  out  M_SCORE_W  live enemy score.
REQ-020 playing_o  out  1  high in ST_PLAY.
REQ-021 game_over_o  out  1  high in ST_GAME_OVER.
REQ-022 winner_o  out  1  1 = player won, 0 = enemy won; meaningful only when game_over_o = 1.

Function
REQ-023 FSM states: ST_WAIT_START, ST_PLAY, ST_GAME_OVER; encoding is free.
REQ-024 ST_WAIT_START -> ST_PLAY on start_i; both scores clear to 0 in the same edge.
REQ-025 ST_PLAY: p_goal_i increments p_score, e_goal_i increments e_score, each by exactly 1 per pulse.
REQ-026 Simultaneous p_goal_i and e_goal_i both count in the same cycle.
REQ-027 ST_PLAY -> ST_GAME_OVER on the edge at which either next score equals MAX_SCORE; scores never exceed MAX_SCORE.
REQ-028 winner_o is registered on that edge: 1 if the next p_score = MAX_SCORE, else 0; if both reach MAX_SCORE together, winner_o = 1.
REQ-029 ST_GAME_OVER -> ST_WAIT_START on start_i; scores and winner_o hold until the next ST_PLAY entry.
REQ-030 Goal pulses outside ST_PLAY are ignored; start_i in ST_PLAY is ignored.
REQ-031 Display copies of both scores load from the live scores only on frame_start_i, so a glyph never changes mid-frame.
REQ-032 Stage 1 registers: per-digit hit (PS_X <= x < PS_X+3*SCALE and PS_Y <= y < PS_Y+5*SCALE, same for ES), glyph column index 0..2 and row index 0..4, and the selected digit value.
REQ-033 Column/row indices are derived by comparing the offset against multiples of SCALE; no divider.
REQ-034 Stage 2 registers score_pix_o = hit AND glyph(digit)[row][col]; latency from x_pos_i/y_pos_i to score_pix_o is exactly 2 cycles.
REQ-035 Glyphs are the team's 3x5 digit set 0..9 (e.g. 0 = 111/101/101/101/111, 1 = 010 on all rows); digit values above 9 render blank.
REQ-036 score_pix_o = 0 whenever the aligned pix_valid_o = 0.
REQ-037 Overlapping digit boxes: player digit takes priority.
REQ-038 Digits render in every FSM state.

Reset
REQ-039 rst_i asserted asynchronously forces ST_WAIT_START, live and display scores 0, winner_o 0, both pipeline stages cleared; all outputs read 0 on the next sample.
REQ-040 Reset mid-game or mid-frame discards all state; the first frame_start_i after release displays 0/0.

Verification
REQ-041 Reset, start_i, three p_goal_i, then frame_start_i -> p_score_o = 3, e_score_o = 0, playing_o = 1; pixel (PS_X+SCALE, PS_Y+SCALE) gives score_pix_o = 0, (PS_X, PS_Y) gives 1, both 2 cycles later.
REQ-042 Goals with no frame_start_i between -> p_score_o updates immediately; rendered digit stays at the old value until frame_start_i.
REQ-043 From 4/4 with MAX_SCORE = 5, simultaneous p_goal_i and e_goal_i -> scores 5/5, game_over_o = 1, winner_o = 1; further goals ignored.
REQ-044 Goal pulses in ST_WAIT_START -> scores stay 0; start_i from ST_GAME_OVER -> ST_WAIT_START with scores held; next start_i -> scores 0.
REQ-045 rst_i asserted mid-frame between clock edges -> outputs 0 immediately, FSM in ST_WAIT_START.
REQ-046 Full-frame raster sweep for each displayed digit 0..5 -> lit pixel count per digit = (lit cells) * SCALE*SCALE, none outside the glyph boxes, none with pix_valid_i = 0.

Source files
------------

// File: rtl/score_display.sv
// Score keeper and score-digit renderer for a two-player ball game.
// A three-state game FSM tracks the live player/enemy scores. Per-frame
// display copies of those scores feed a two-stage pixel pipeline, which
// marks the pixels that fall on a lit cell of either 3x5 digit glyph.
module score_display #(
  parameter int SCREEN_H_RES = 640,
  parameter int X_POS_W      = 10,
  parameter int Y_POS_W      = 10,
  parameter int M_SCORE_W    = 4,
  parameter int MAX_SCORE    = 5,
  parameter int PS_X         = SCREEN_H_RES - 120,
  parameter int PS_Y         = 50,
  parameter int ES_X         = 120,
  parameter int ES_Y         = 50,
  parameter int SCALE        = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 p_goal_i,
  input  logic                 e_goal_i,
  input  logic                 frame_start_i,
  input  logic                 pix_valid_i,
  input  logic [X_POS_W-1:0]   x_pos_i,
  input  logic [Y_POS_W-1:0]   y_pos_i,
  output logic                 score_pix_o,
  output logic                 pix_valid_o,
  output logic [M_SCORE_W-1:0] p_score_o,
  output logic [M_SCORE_W-1:0] e_score_o,
  output logic                 playing_o,
  output logic                 game_over_o,
  output logic                 winner_o
);

  // One extra bit keeps box upper bounds representable near the edge of
  // the coordinate range.
  localparam int XW = X_POS_W + 1;
  localparam int YW = Y_POS_W + 1;

  localparam logic [M_SCORE_W-1:0] C_MAX = M_SCORE_W'(MAX_SCORE);

  localparam logic [XW-1:0] C_PX_LO = XW'(PS_X);
  localparam logic [XW-1:0] C_PX_HI = XW'(PS_X + 3 * SCALE);
  localparam logic [XW-1:0] C_EX_LO = XW'(ES_X);
  localparam logic [XW-1:0] C_EX_HI = XW'(ES_X + 3 * SCALE);
  localparam logic [YW-1:0] C_PY_LO = YW'(PS_Y);
  localparam logic [YW-1:0] C_PY_HI = YW'(PS_Y + 5 * SCALE);
  localparam logic [YW-1:0] C_EY_LO = YW'(ES_Y);
  localparam logic [YW-1:0] C_EY_HI = YW'(ES_Y + 5 * SCALE);

  // Cell boundaries inside a glyph box, as offsets from its top-left.
  localparam logic [XW-1:0] C_XS1 = XW'(SCALE);
  localparam logic [XW-1:0] C_XS2 = XW'(2 * SCALE);
  localparam logic [YW-1:0] C_YS1 = YW'(SCALE);
  localparam logic [YW-1:0] C_YS2 = YW'(2 * SCALE);
  localparam logic [YW-1:0] C_YS3 = YW'(3 * SCALE);
  localparam logic [YW-1:0] C_YS4 = YW'(4 * SCALE);

  typedef enum logic [1:0] {
    ST_WAIT_START = 2'd0,
    ST_PLAY       = 2'd1,
    ST_GAME_OVER  = 2'd2
  } state_t;

  state_t               r_state;
  logic [M_SCORE_W-1:0] r_p_score;
  logic [M_SCORE_W-1:0] r_e_score;
  logic [M_SCORE_W-1:0] r_p_disp;
  logic [M_SCORE_W-1:0] r_e_disp;
  logic                 r_winner;
  logic                 r_playing;
  logic                 r_game_over;

  logic [M_SCORE_W-1:0] w_p_next;
  logic [M_SCORE_W-1:0] w_e_next;

  logic [XW-1:0]        w_x;
  logic [YW-1:0]        w_y;
  logic                 w_p_hit;
  logic                 w_e_hit;
  logic [XW-1:0]        w_x_off;
  logic [YW-1:0]        w_y_off;
  logic [M_SCORE_W-1:0] w_digit;

  logic                 r_hit_p1;
  logic                 r_vld_p1;
  logic [1:0]           r_col_p1;
  logic [2:0]           r_row_p1;
  logic [M_SCORE_W-1:0] r_digit_p1;
  logic                 r_pix_p2;
  logic                 r_vld_p2;

  // Glyph column 0..2 from the horizontal offset into the box.
  function automatic logic [1:0] cell_col(input logic [XW-1:0] off);
    logic [1:0] c;
    if (off < C_XS1)      c = 2'd0;
    else if (off < C_XS2) c = 2'd1;
    else                  c = 2'd2;
    return c;
  endfunction

  // Glyph row 0..4 from the vertical offset into the box.
  function automatic logic [2:0] cell_row(input logic [YW-1:0] off);
    logic [2:0] r;
    if (off < C_YS1)      r = 3'd0;
    else if (off < C_YS2) r = 3'd1;
    else if (off < C_YS3) r = 3'd2;
    else if (off < C_YS4) r = 3'd3;
    else                  r = 3'd4;
    return r;
  endfunction

  // 3x5 digit font: 15 bits, row 0 in the top three bits, column 0 is the
  // leftmost (most significant) bit of each row. Non-decimal values are blank.
  function automatic logic glyph_bit(input logic [M_SCORE_W-1:0] d,
                                     input logic [2:0]           row,
                                     input logic [1:0]           col);
    logic [14:0] pat;
    logic [3:0]  idx;
    case (int'(d))
      0:       pat = 15'b111_101_101_101_111;
      1:       pat = 15'b010_010_010_010_010;
      2:       pat = 15'b111_001_111_100_111;
      3:       pat = 15'b111_001_111_001_111;
      4:       pat = 15'b101_101_111_001_001;
      5:       pat = 15'b111_100_111_001_111;
      6:       pat = 15'b111_100_111_101_111;
      7:       pat = 15'b111_001_001_001_001;
      8:       pat = 15'b111_101_111_101_111;
      9:       pat = 15'b111_101_111_001_111;
      default: pat = 15'b000_000_000_000_000;
    endcase
    idx = 4'd14 - (4'(row) * 4'd3 + 4'(col));
    return pat[idx];
  endfunction

  // Scores as they would be after this cycle's goal pulses.
  always_comb begin
    w_p_next = r_p_score + {{(M_SCORE_W-1){1'b0}}, p_goal_i};
    w_e_next = r_e_score + {{(M_SCORE_W-1){1'b0}}, e_goal_i};
  end

  // Game FSM with registered status outputs and live scores.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_WAIT_START;
      r_p_score   <= '0;
      r_e_score   <= '0;
      r_winner    <= 1'b0;
      r_playing   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      case (r_state)
        ST_WAIT_START: begin
          if (start_i) begin
            r_state     <= ST_PLAY;
            r_p_score   <= '0;
            r_e_score   <= '0;
            r_winner    <= 1'b0;
            r_playing   <= 1'b1;
            r_game_over <= 1'b0;
          end
        end
        ST_PLAY: begin
          r_p_score <= w_p_next;
          r_e_score <= w_e_next;
          // Player wins a simultaneous final goal.
          if ((w_p_next == C_MAX) || (w_e_next == C_MAX)) begin
            r_state     <= ST_GAME_OVER;
            r_winner    <= (w_p_next == C_MAX);
            r_playing   <= 1'b0;
            r_game_over <= 1'b1;
          end
        end
        ST_GAME_OVER: begin
          if (start_i) begin
            r_state     <= ST_WAIT_START;
            r_game_over <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_WAIT_START;
          r_playing   <= 1'b0;
          r_game_over <= 1'b0;
        end
      endcase
    end
  end

  // Display copies change only at frame start so a glyph never tears.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_p_disp <= '0;
      r_e_disp <= '0;
    end else if (frame_start_i) begin
      r_p_disp <= r_p_score;
      r_e_disp <= r_e_score;
    end
  end

  // Box hit tests on the zero-extended pixel position.
  always_comb begin
    w_x     = {1'b0, x_pos_i};
    w_y     = {1'b0, y_pos_i};
    w_p_hit = (w_x >= C_PX_LO) && (w_x < C_PX_HI) &&
              (w_y >= C_PY_LO) && (w_y < C_PY_HI);
    w_e_hit = (w_x >= C_EX_LO) && (w_x < C_EX_HI) &&
              (w_y >= C_EY_LO) && (w_y < C_EY_HI);
  end

  // Offset and digit selection; the player box wins where the boxes overlap.
  always_comb begin
    w_x_off = w_x - C_EX_LO;
    w_y_off = w_y - C_EY_LO;
    w_digit = r_e_disp;
    if (w_p_hit) begin
      w_x_off = w_x - C_PX_LO;
      w_y_off = w_y - C_PY_LO;
      w_digit = r_p_disp;
    end
  end

  // ---- stage 1: box hit, glyph cell index, digit value ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hit_p1   <= 1'b0;
      r_vld_p1   <= 1'b0;
      r_col_p1   <= '0;
      r_row_p1   <= '0;
      r_digit_p1 <= '0;
    end else begin
      r_hit_p1   <= (w_p_hit || w_e_hit) && pix_valid_i;
      r_vld_p1   <= pix_valid_i;
      r_col_p1   <= cell_col(w_x_off);
      r_row_p1   <= cell_row(w_y_off);
      r_digit_p1 <= w_digit;
    end
  end

  // ---- stage 2: font lookup, gated by hit and valid ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pix_p2 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_pix_p2 <= r_hit_p1 && r_vld_p1 &&
                  glyph_bit(r_digit_p1, r_row_p1, r_col_p1);
      r_vld_p2 <= r_vld_p1;
    end
  end

  assign score_pix_o = r_pix_p2;
  assign pix_valid_o = r_vld_p2;
  assign p_score_o   = r_p_score;
  assign e_score_o   = r_e_score;
  assign playing_o   = r_playing;
  assign game_over_o = r_game_over;
  assign winner_o    = r_winner;

endmodule
